// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and helpers for the load/store unit.
//   func3 codes   : F3_B, F3_H, F3_W, F3_BU, F3_HU
//   state type    : lsu_state_t, one-hot (LSU_IDLE, LSU_ISSUE, LSU_WAIT, LSU_DONE)
//   lsu_fault()   : misaligned / illegal-width detection for a request
//   lsu_wmask()   : byte-lane write enables for a store
//   lsu_sdata()   : lane-replicated store data
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [3:0] {
    LSU_IDLE  = 4'b0001,
    LSU_ISSUE = 4'b0010,
    LSU_WAIT  = 4'b0100,
    LSU_DONE  = 4'b1000
  } lsu_state_t;

  // Unsigned widths are load-only; any store with them is illegal.
  function automatic logic lsu_fault(input logic       st,
                                     input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic f;
    f = 1'b0;
    case (f3)
      F3_B:    f = 1'b0;
      F3_H:    f = lo[0];
      F3_W:    f = |lo;
      F3_BU:   f = st;
      F3_HU:   f = st | lo[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] lsu_wmask(input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      F3_B:    m = 4'b0001 << lo;
      F3_H:    m = 4'b0011 << lo;
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lsu_sdata(input logic [2:0]  f3,
                                            input logic [31:0] sd);
    logic [31:0] d;
    d = sd;
    case (f3)
      F3_B:    d = {4{sd[7:0]}};
      F3_H:    d = {2{sd[15:0]}};
      default: d = sd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational lane select and extension of a BRAM word.
//   ld_mem : raw 32-bit word from the BRAM
//   addr   : low two bits of the byte address (byte lane / halfword lane)
//   func3  : access width and signedness
//   ldata  : extended result; 0 for codes that are not loads
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_mem,
  input  logic [1:0]  addr,
  input  logic [2:0]  func3,
  output logic [31:0] ldata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = ld_mem[{addr, 3'b000} +: 8];
    half_v = addr[1] ? ld_mem[31:16] : ld_mem[15:0];
    ldata  = 32'd0;
    case (func3)
      F3_B:    ldata = {{24{byte_v[7]}}, byte_v};
      F3_H:    ldata = {{16{half_v[15]}}, half_v};
      F3_W:    ldata = ld_mem;
      F3_BU:   ldata = {24'd0, byte_v};
      F3_HU:   ldata = {16'd0, half_v};
      default: ldata = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the execute stage and the data BRAM port.
//   clk, rstn      : clock, synchronous active-low reset
//   order          : request strobe, sampled only when idle
//   store          : 1 = store, 0 = load
//   func3          : access width (RISC-V encoding)
//   addr, sdata    : byte address and store data
//   ld_mem         : BRAM read data, valid READ_LATENCY cycles after mem_read_flag
//   accepted       : one-cycle pulse, request latched
//   accessed       : one-cycle pulse, ldata/fault valid (both held afterwards)
//   a_mem, sd_mem  : BRAM word address and lane-replicated store data
//   mem_write_flag : byte write enables, mem_read_flag : read enable
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LSU_IDLE  | waiting for order; request latched and BRAM port driven
// LSU_ISSUE | enables on the BRAM port for this one cycle, accepted high
// LSU_WAIT  | load in flight, counting down the BRAM read latency
// LSU_DONE  | accessed high for one cycle
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W       = 17,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              order,
  input  logic              store,
  input  logic [2:0]        func3,
  input  logic [31:0]       addr,
  input  logic [31:0]       sdata,
  input  logic [31:0]       ld_mem,
  output logic              accepted,
  output logic              accessed,
  output logic [31:0]       ldata,
  output logic              fault,
  output logic [ADDR_W-1:0] a_mem,
  output logic [31:0]       sd_mem,
  output logic [3:0]        mem_write_flag,
  output logic              mem_read_flag
);

  localparam int CNT_W = 3;

  lsu_state_t       state;
  logic             store_q;
  logic             fault_q;
  logic [2:0]       func3_q;
  logic [1:0]       lo_q;
  logic [CNT_W-1:0] cnt;

  logic             req_fault;
  logic [31:0]      align_word;
  logic             unused_addr_hi;

  assign req_fault      = lsu_fault(store, func3, addr[1:0]);
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  lsu_load_align u_align (
    .ld_mem (ld_mem),
    .addr   (lo_q),
    .func3  (func3_q),
    .ldata  (align_word)
  );

  // The BRAM-facing outputs are computed on the edge that latches the request,
  // so that they are registered yet already valid in the ISSUE cycle. The
  // counter is loaded on that same edge and also ticks in ISSUE, so it hits
  // zero exactly in the cycle ld_mem becomes valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= LSU_IDLE;
      store_q        <= 1'b0;
      fault_q        <= 1'b0;
      func3_q        <= 3'd0;
      lo_q           <= 2'd0;
      cnt            <= '0;
      accepted       <= 1'b0;
      accessed       <= 1'b0;
      ldata          <= 32'd0;
      fault          <= 1'b0;
      a_mem          <= '0;
      sd_mem         <= 32'd0;
      mem_write_flag <= 4'd0;
      mem_read_flag  <= 1'b0;
    end else begin
      accepted       <= 1'b0;
      accessed       <= 1'b0;
      mem_write_flag <= 4'd0;
      mem_read_flag  <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (order) begin
            store_q  <= store;
            fault_q  <= req_fault;
            func3_q  <= func3;
            lo_q     <= addr[1:0];
            cnt      <= CNT_W'(READ_LATENCY);
            a_mem    <= addr[ADDR_W+1:2];
            sd_mem   <= lsu_sdata(func3, sdata);
            accepted <= 1'b1;
            if (!req_fault) begin
              if (store) mem_write_flag <= lsu_wmask(func3, addr[1:0]);
              else       mem_read_flag  <= 1'b1;
            end
            state <= LSU_ISSUE;
          end
        end
        LSU_ISSUE: begin
          cnt <= cnt - 1'b1;
          if (fault_q) begin
            ldata    <= 32'd0;
            fault    <= 1'b1;
            accessed <= 1'b1;
            state    <= LSU_DONE;
          end else if (store_q) begin
            fault    <= 1'b0;
            accessed <= 1'b1;
            state    <= LSU_DONE;
          end else begin
            state <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (cnt == '0) begin
            ldata    <= align_word;
            fault    <= 1'b0;
            accessed <= 1'b1;
            state    <= LSU_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LSU_DONE: begin
          state <= LSU_IDLE;
        end
        default: begin
          state <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        order [2];
  logic        store [2];
  logic [2:0]  func3 [2];
  logic [31:0] addr [2];
  logic [31:0] sdata [2];
  logic [31:0] ld_mem [2];
  logic        accepted [2];
  logic        accessed [2];
  logic [31:0] ldata [2];
  logic        fault [2];
  logic [16:0] a_mem [2];
  logic [31:0] sd_mem [2];
  logic [3:0]  mem_write_flag [2];
  logic        mem_read_flag [2];

  logic [31:0] mem [2][256];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit rst_pend = 1;

  // expectations, owned by the stimulus process
  int          acc_cyc [2] = '{-1, -1};
  int          done_cyc [2] = '{-1, -1};
  bit          e_rd [2];
  logic [3:0]  e_we [2];
  logic [16:0] e_amem [2];
  logic [31:0] e_sd [2];
  logic [31:0] e_ld [2];
  bit          e_f [2];
  bit          e_upd [2];
  // held-output model, owned by the compare process
  logic [31:0] h_ld [2] = '{32'd0, 32'd0};
  logic        h_f [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu #(.ADDR_W(17), .READ_LATENCY(1)) dut0 (
    .clk(clk), .rstn(rstn), .order(order[0]), .store(store[0]), .func3(func3[0]),
    .addr(addr[0]), .sdata(sdata[0]), .ld_mem(ld_mem[0]), .accepted(accepted[0]),
    .accessed(accessed[0]), .ldata(ldata[0]), .fault(fault[0]), .a_mem(a_mem[0]),
    .sd_mem(sd_mem[0]), .mem_write_flag(mem_write_flag[0]), .mem_read_flag(mem_read_flag[0]));

  lsu #(.ADDR_W(17), .READ_LATENCY(3)) dut1 (
    .clk(clk), .rstn(rstn), .order(order[1]), .store(store[1]), .func3(func3[1]),
    .addr(addr[1]), .sdata(sdata[1]), .ld_mem(ld_mem[1]), .accepted(accepted[1]),
    .accessed(accessed[1]), .ldata(ldata[1]), .fault(fault[1]), .a_mem(a_mem[1]),
    .sd_mem(sd_mem[1]), .mem_write_flag(mem_write_flag[1]), .mem_read_flag(mem_read_flag[1]));

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // BRAM models: read registered on mem_read_flag, then delayed to the latency.
  for (genvar g = 0; g < 2; g++) begin : g_bram
    logic [31:0] p [4];
    always @(posedge clk) begin
      if (mem_read_flag[g]) p[0] <= mem[g][a_mem[g][7:0]];
      p[1] <= p[0];
      p[2] <= p[1];
      p[3] <= p[2];
    end
    assign ld_mem[g] = p[lat(g) - 1];
  end

  // ---------------- behavioural model ----------------
  function automatic int m_nbytes(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 > 5) return 1;
    if (st && f3 > 2) return 1;
    return (a % m_nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    longint lim, v;
    lim = 64'd1 << (8 * m_nbytes(f3));
    v = ({32'd0, w} >> (8 * (a % 4))) % lim;
    if (f3 < 4 && m_nbytes(f3) < 4 && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << m_nbytes(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_sd(input logic [2:0] f3, input logic [31:0] sd);
    if (m_nbytes(f3) == 1) return {24'd0, sd[7:0]} * 32'h01010101;
    if (m_nbytes(f3) == 2) return {16'd0, sd[15:0]} * 32'h00010001;
    return sd;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_pend) begin
      for (int k = 0; k < 2; k++) begin
        h_ld[k] = 32'd0;
        h_f[k] = 1'b0;
      end
    end
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        if (cyc == done_cyc[k]) begin
          h_f[k] = e_f[k];
          if (e_upd[k]) h_ld[k] = e_ld[k];
        end
        chk("accepted", k, 32'(accepted[k]), 32'(cyc == acc_cyc[k]));
        chk("accessed", k, 32'(accessed[k]), 32'(cyc == done_cyc[k]));
        chk("mem_read_flag", k, 32'(mem_read_flag[k]), 32'(cyc == acc_cyc[k] && e_rd[k]));
        chk("mem_write_flag", k, 32'(mem_write_flag[k]), (cyc == acc_cyc[k]) ? 32'(e_we[k]) : 32'd0);
        chk("ldata", k, ldata[k], h_ld[k]);
        chk("fault", k, 32'(fault[k]), 32'(h_f[k]));
        if (cyc == acc_cyc[k]) begin
          chk("a_mem", k, 32'(a_mem[k]), 32'(e_amem[k]));
          if (e_we[k] != 0) chk("sd_mem", k, sd_mem[k], e_sd[k]);
        end
      end
    end
    rst_pend = !rstn;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int k, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    bit f;
    store[k] = st; func3[k] = f3; addr[k] = a; sdata[k] = sd; order[k] = 1'b1;
    f = m_fault(st, f3, a);
    e_f[k] = f;
    e_rd[k] = !f && !st;
    e_we[k] = (!f && st) ? m_mask(f3, a) : 4'd0;
    e_amem[k] = 17'((a >> 2) % (1 << 17));
    e_sd[k] = m_sd(f3, sd);
    e_ld[k] = f ? 32'd0 : m_ld(mem[k][(a >> 2) % 256], a, f3);
    e_upd[k] = f || !st;
    acc_cyc[k] = cyc + 1;
    done_cyc[k] = cyc + 2 + (e_rd[k] ? lat(k) : 0);
  endtask

  task automatic run(input int k, input bit st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd, input bit poke);
    @(posedge clk); #1;
    issue(k, st, f3, a, sd);
    @(posedge clk); #1;
    order[k] = 1'b0;
    if (poke) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      store[k] = 1'b1; func3[k] = 3'd2; addr[k] = 32'h200; order[k] = 1'b1;
      @(posedge clk); #1;
      order[k] = 1'b0;
      repeat (lat(k) + 2) @(posedge clk);
    end else begin
      repeat (lat(k) + 3) @(posedge clk);
    end
  endtask

  task automatic chk_zero(input int k);
    chk("rst accepted", k, 32'(accepted[k]), 32'd0);
    chk("rst accessed", k, 32'(accessed[k]), 32'd0);
    chk("rst ldata", k, ldata[k], 32'd0);
    chk("rst fault", k, 32'(fault[k]), 32'd0);
    chk("rst a_mem", k, 32'(a_mem[k]), 32'd0);
    chk("rst sd_mem", k, sd_mem[k], 32'd0);
    chk("rst mem_write_flag", k, 32'(mem_write_flag[k]), 32'd0);
    chk("rst mem_read_flag", k, 32'(mem_read_flag[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      order[k] = 0; store[k] = 0; func3[k] = 0; addr[k] = 0; sdata[k] = 0;
      e_rd[k] = 0; e_we[k] = 0; e_amem[k] = 0; e_sd[k] = 0; e_ld[k] = 0; e_f[k] = 0; e_upd[k] = 0;
      for (int i = 0; i < 256; i++) mem[k][i] = 32'h0;
    end
    mem[0][8'h40] = 32'hDEADBEEF;
    mem[1][8'h10] = 32'h98760000;
    mem[1][8'h40] = 32'hCAFEF00D;

    // model pinned to hand-computed values
    chk("model LB", 0, m_ld(32'h80112233, 32'h103, 3'd0), 32'hFFFFFF80);
    chk("model LBU", 0, m_ld(32'h80112233, 32'h103, 3'd4), 32'h00000080);
    chk("model LHU", 0, m_ld(32'h98760000, 32'h42, 3'd5), 32'h00009876);
    chk("model SH mask", 0, 32'(m_mask(3'd1, 32'h22)), 32'h0000000C);
    chk("model SH data", 0, m_sd(3'd1, 32'h0000ABCD), 32'hABCDABCD);
    chk("model LW fault", 0, 32'(m_fault(1'b0, 3'd2, 32'h102)), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    rstn = 1'b1;
    chk_en = 1'b1;

    // READ_LATENCY = 1
    run(0, 0, 3'd2, 32'h100, 32'h0, 0);                 // LW
    chk("LW ldata", 0, ldata[0], 32'hDEADBEEF);
    chk("LW a_mem", 0, 32'(a_mem[0]), 32'h40);
    mem[0][8'h40] = 32'h80112233;
    run(0, 0, 3'd0, 32'h103, 32'h0, 0);                 // LB
    chk("LB ldata", 0, ldata[0], 32'hFFFFFF80);
    run(0, 0, 3'd4, 32'h103, 32'h0, 0);                 // LBU
    chk("LBU ldata", 0, ldata[0], 32'h00000080);
    run(0, 0, 3'd1, 32'h102, 32'h0, 0);                 // LH upper lane
    run(0, 0, 3'd5, 32'h100, 32'h0, 0);                 // LHU lower lane
    run(0, 0, 3'd0, 32'h101, 32'h0, 0);                 // LB lane 1
    run(0, 1, 3'd1, 32'h22, 32'h0000ABCD, 0);           // SH
    chk("SH sd_mem", 0, sd_mem[0], 32'hABCDABCD);
    run(0, 1, 3'd0, 32'h13, 32'h1234565A, 0);           // SB lane 3
    run(0, 1, 3'd2, 32'h40, 32'h01234567, 0);           // SW
    run(0, 0, 3'd2, 32'h102, 32'h0, 0);                 // LW misaligned
    chk("LW misaligned fault", 0, 32'(fault[0]), 32'd1);
    chk("LW misaligned ldata", 0, ldata[0], 32'd0);
    run(0, 1, 3'd1, 32'h21, 32'h0000ABCD, 0);           // SH misaligned
    run(0, 0, 3'd3, 32'h100, 32'h0, 0);                 // illegal func3
    run(0, 1, 3'd4, 32'h100, 32'h0, 0);                 // store with load-only width
    run(0, 0, 3'd2, 32'h100, 32'h0, 0);                 // clean load clears fault

    // READ_LATENCY = 3, order pulse during WAIT is ignored
    run(1, 0, 3'd5, 32'h42, 32'h0, 1);                  // LHU
    chk("LHU ldata", 1, ldata[1], 32'h00009876);
    run(1, 0, 3'd0, 32'h103, 32'h0, 0);                 // LB from 0xCAFEF00D
    run(1, 1, 3'd2, 32'h44, 32'hA5A5_0F0F, 0);          // SW

    // reset while the load waits on the BRAM
    @(posedge clk); #1;
    issue(1, 0, 3'd2, 32'h100, 32'h0);
    @(posedge clk); #1;
    order[1] = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    done_cyc[1] = -1;
    @(posedge clk); #1;
    chk_zero(1);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    run(1, 1, 3'd2, 32'h48, 32'h13579BDF, 0);           // fresh SW
    run(1, 0, 3'd2, 32'h100, 32'h0, 0);                 // and a load
    chk("post-reset LW ldata", 1, ldata[1], 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's execute stage and the data BRAM port. It accepts one access per order pulse, with byte, halfword or word width selected by RISC-V func3. It drives word address, byte-lane write enables and replicated store data, waits a parameterised BRAM read latency, and returns sign- or zero-extended load data with an `accessed` pulse. Misaligned and illegal-width requests complete without touching memory and raise `fault`.

## Interface
- `ADDR_W`, default 17: word-address width of the data BRAM, equal to `LEN_MEMDATA_ADDR`.
- `READ_LATENCY`, default 1: cycles from the cycle `mem_read_flag` is high to the cycle `ld_mem` is valid. Legal range is 1..4.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `order`  in  1  request strobe; sampled only in IDLE.
- `store`  in  1  1 = store, 0 = load; sampled with `order`.
- `func3`  in  3  access width: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- `addr`  in  32  byte address; sampled with `order`.
- `sdata`  in  32  store data; sampled with `order`.
- `accepted`  out  1  one-cycle pulse: request latched.
- `accessed`  out  1  one-cycle pulse: access complete; `ldata` and `fault` are valid.
- `ldata`  out  32  extended load data; held until the next `accessed`.
- `fault`  out  1  misaligned or illegal func3; valid with `accessed`, held.
- `a_mem`  out  ADDR_W  word address, `addr[ADDR_W+1:2]`.
- `sd_mem`  out  32  lane-replicated store data.
- `mem_write_flag`  out  4  byte write enables; bit i covers `sd_mem[8i+7:8i]`.
- `mem_read_flag`  out  1  read enable.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, `order`=1: latch `store`, `func3`, `addr` and `sdata`, then go to ISSUE. `order` in any other state is ignored and not queued.
- ISSUE: `accepted`=1.
  - Fault check: `fault` is set for any of the following.
    - `func3` not in {0,1,2,4,5}.
    - A store with `func3` greater than 2.
    - LH, LHU or SH with `addr[0]`=1.
    - LW or SW with `addr[1:0]` not 00.
  - Fault: no enables asserted; next state DONE with `ldata`=0.
  - Store: `mem_write_flag` = 0001 << `addr[1:0]` for SB, 0011 << `addr[1:0]` for SH, 1111 for SW. Next state DONE.
  - Store data: `sd_mem` = {4{sdata[7:0]}} for SB, {2{sdata[15:0]}} for SH, `sdata` for SW.
  - Load: `mem_read_flag`=1; load a down-counter with READ_LATENCY; next state WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, capture `ld_mem` into `ldata`, then go to DONE.
  - Lane select: byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
  - Extension: func3 0 and 1 sign-extend; func3 4 and 5 zero-extend; func3 2 passes the word through.
- DONE: `accessed`=1 for one cycle, then IDLE.
- `a_mem`, `sd_mem`, `mem_write_flag` and `mem_read_flag` are registered. The enables are high only during the ISSUE cycle; at all other times they are 0.
- Endianness: little-endian; byte 0 is bits 7:0.

## Timing
- Reset values: state IDLE, and every output 0 (`accepted`, `accessed`, `ldata`, `fault`, `a_mem`, `sd_mem`, `mem_write_flag`, `mem_read_flag`).
- Reset mid-operation discards the pending access. A read already issued to the BRAM is ignored, and no `accessed` pulse is produced.
- Latency is counted from the `order` cycle, T0.
  - `accepted` is high at T1.
  - Store or fault: `accessed` at T2.
  - Load: `accessed` at T2+READ_LATENCY.
- Throughput: the next `order` is sampled no earlier than the cycle after `accessed`.
- `order` is level-tolerant: if it is still high when the unit returns to IDLE, a new request starts. The caller must deassert `order` after `accepted`.

## Structure
- Constants in `include.vh`: func3 codes `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`; state encodings `LSU_IDLE`, `LSU_ISSUE`, `LSU_WAIT`, `LSU_DONE` (one-hot).
- Sub-module `load_align` (combinational): inputs `ld_mem`, `addr[1:0]`, `func3`; output the extended 32-bit word.
- Target size: 150–250 lines total.

## Test plan
- LW, `addr`=0x100, BRAM word 0xDEADBEEF, READ_LATENCY=1 -> `a_mem`=0x40, `mem_read_flag` high at T1, `accessed` at T3 with `ldata`=0xDEADBEEF and `fault`=0.
- LB and LBU, `addr`=0x103, word 0x80112233 -> LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SH, `addr`=0x22, `sdata`=0x0000ABCD -> `mem_write_flag`=1100 and `sd_mem`=0xABCDABCD at T1, `accessed` at T2.
- LW at `addr`=0x102 and SH at `addr`=0x21 -> `fault`=1 at `accessed` at T2, both enables 0 throughout, `ldata`=0.
- READ_LATENCY=3 with LHU at `addr`=0x42, word 0x9876_0000 -> `accessed` at T5 with `ldata`=0x00009876. An `order` pulse during WAIT is ignored.
- Assert `rstn`=0 in the WAIT state -> next cycle all outputs 0 and state IDLE. No `accessed` pulse; a fresh SW afterwards completes normally.
